// File: rtl/alu.sv
// Phaethon multi-cycle 32-bit core: fetches from byte-addressed memory over a
// pulsed request/acknowledge bus and executes on a four-entry register file.
module alu (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ramValue,
    input  logic        readAck,
    input  logic        writeAck,
    output logic [31:0] ramAddress,
    output logic [31:0] ramOut,
    output logic        readReq,
    output logic        writeReq,
    output logic [7:0]  iPointer,
    output logic [7:0]  opCode,
    output logic [31:0] r0,
    output logic [31:0] r1,
    output logic [31:0] r2,
    output logic [31:0] debug
);

    typedef enum logic [2:0] {
        FETCH_REQ  = 3'd0,
        FETCH_WAIT = 3'd1,
        IMM_REQ    = 3'd2,
        IMM_WAIT   = 3'd3,
        EXEC       = 3'd4,
        MEM_REQ    = 3'd5,
        MEM_WAIT   = 3'd6,
        HALTED     = 3'd7
    } state_t;

    localparam logic [7:0] OP_MOVI  = 8'h00;
    localparam logic [7:0] OP_MOV   = 8'h01;
    localparam logic [7:0] OP_ADD   = 8'h02;
    localparam logic [7:0] OP_SUB   = 8'h03;
    localparam logic [7:0] OP_AND   = 8'h04;
    localparam logic [7:0] OP_OR    = 8'h05;
    localparam logic [7:0] OP_XOR   = 8'h06;
    localparam logic [7:0] OP_ADDI  = 8'h07;
    localparam logic [7:0] OP_LOAD  = 8'h08;
    localparam logic [7:0] OP_STORE = 8'h09;
    localparam logic [7:0] OP_JMP   = 8'h0A;
    localparam logic [7:0] OP_JZ    = 8'h0B;
    localparam logic [7:0] OP_JNZ   = 8'h0C;
    localparam logic [7:0] OP_SHL   = 8'h0D;
    localparam logic [7:0] OP_SHR   = 8'h0E;
    localparam logic [7:0] OP_HALT  = 8'h0F;

    function automatic logic hasImm(input logic [7:0] op);
        case (op)
            OP_MOVI, OP_ADDI, OP_JMP, OP_JZ, OP_JNZ: hasImm = 1'b1;
            default:                                 hasImm = 1'b0;
        endcase
    endfunction

    function automatic logic isMemOp(input logic [7:0] op);
        case (op)
            OP_LOAD, OP_STORE: isMemOp = 1'b1;
            default:           isMemOp = 1'b0;
        endcase
    endfunction

    state_t      stateR;
    state_t      nextStateS;
    logic [31:0] regFile [0:3];
    logic [31:0] immR;
    logic [1:0]  srcAIdxR;
    logic [1:0]  srcBIdxR;
    logic [31:0] opAS;
    logic [31:0] opBS;
    logic [31:0] aluResultS;
    logic        aluWriteS;
    logic [7:0]  nextIpS;
    logic [7:0]  ipPlusOneS;
    logic [7:0]  ipPlusTwoS;

    assign r0    = regFile[0];
    assign r1    = regFile[1];
    assign r2    = regFile[2];
    assign debug = regFile[3];

    assign opAS       = regFile[srcAIdxR];
    assign opBS       = regFile[srcBIdxR];
    assign ipPlusOneS = iPointer + 8'd1;
    assign ipPlusTwoS = iPointer + 8'd2;

    // Execute-stage result, register write enable and next instruction pointer
    always_comb begin
        aluResultS = 32'd0;
        aluWriteS  = 1'b0;
        if (hasImm(opCode)) begin
            nextIpS = ipPlusTwoS;
        end else begin
            nextIpS = ipPlusOneS;
        end
        case (opCode)
            OP_MOVI: begin aluResultS = immR;               aluWriteS = 1'b1; end
            OP_MOV:  begin aluResultS = opBS;               aluWriteS = 1'b1; end
            OP_ADD:  begin aluResultS = opAS + opBS;        aluWriteS = 1'b1; end
            OP_SUB:  begin aluResultS = opAS - opBS;        aluWriteS = 1'b1; end
            OP_AND:  begin aluResultS = opAS & opBS;        aluWriteS = 1'b1; end
            OP_OR:   begin aluResultS = opAS | opBS;        aluWriteS = 1'b1; end
            OP_XOR:  begin aluResultS = opAS ^ opBS;        aluWriteS = 1'b1; end
            OP_ADDI: begin aluResultS = opAS + immR;        aluWriteS = 1'b1; end
            OP_SHL:  begin aluResultS = opAS << opBS[4:0];  aluWriteS = 1'b1; end
            OP_SHR:  begin aluResultS = opAS >> opBS[4:0];  aluWriteS = 1'b1; end
            OP_JMP:  nextIpS = immR[7:0];
            OP_JZ: begin
                if (opAS == 32'd0) begin
                    nextIpS = immR[7:0];
                end else begin
                    nextIpS = ipPlusTwoS;
                end
            end
            OP_JNZ: begin
                if (opAS != 32'd0) begin
                    nextIpS = immR[7:0];
                end else begin
                    nextIpS = ipPlusTwoS;
                end
            end
            default: aluWriteS = 1'b0;
        endcase
    end

    // Sequencer next-state decode
    always_comb begin
        nextStateS = stateR;
        case (stateR)
            FETCH_REQ: nextStateS = FETCH_WAIT;
            FETCH_WAIT: begin
                if (readAck) begin
                    if (hasImm(ramValue[7:0])) begin
                        nextStateS = IMM_REQ;
                    end else begin
                        nextStateS = EXEC;
                    end
                end else begin
                    nextStateS = FETCH_WAIT;
                end
            end
            IMM_REQ: nextStateS = IMM_WAIT;
            IMM_WAIT: begin
                if (readAck) begin
                    nextStateS = EXEC;
                end else begin
                    nextStateS = IMM_WAIT;
                end
            end
            EXEC: begin
                if (isMemOp(opCode)) begin
                    nextStateS = MEM_REQ;
                end else if (opCode >= OP_HALT) begin
                    nextStateS = HALTED;
                end else begin
                    nextStateS = FETCH_REQ;
                end
            end
            MEM_REQ: nextStateS = MEM_WAIT;
            MEM_WAIT: begin
                if (opCode == OP_STORE) begin
                    if (writeAck) begin
                        nextStateS = FETCH_REQ;
                    end else begin
                        nextStateS = MEM_WAIT;
                    end
                end else begin
                    if (readAck) begin
                        nextStateS = FETCH_REQ;
                    end else begin
                        nextStateS = MEM_WAIT;
                    end
                end
            end
            HALTED:  nextStateS = HALTED;
            default: nextStateS = FETCH_REQ;
        endcase
    end

    // Sequencer state register
    always_ff @(posedge clk) begin
        if (reset) begin
            stateR <= FETCH_REQ;
        end else begin
            stateR <= nextStateS;
        end
    end

    // Bus outputs, decoded fields, immediate, pointer and register file
    always_ff @(posedge clk) begin
        if (reset) begin
            ramAddress <= 32'd0;
            ramOut     <= 32'd0;
            readReq    <= 1'b0;
            writeReq   <= 1'b0;
            iPointer   <= 8'd0;
            opCode     <= 8'd0;
            immR       <= 32'd0;
            srcAIdxR   <= 2'd0;
            srcBIdxR   <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                regFile[i] <= 32'd0;
            end
        end else begin
            // request strobes are one-cycle pulses; REQ states re-raise them
            readReq  <= 1'b0;
            writeReq <= 1'b0;
            case (stateR)
                FETCH_REQ: begin
                    readReq    <= 1'b1;
                    ramAddress <= {22'd0, iPointer, 2'b00};
                end
                FETCH_WAIT: begin
                    if (readAck) begin
                        opCode   <= ramValue[7:0];
                        srcAIdxR <= ramValue[9:8];
                        srcBIdxR <= ramValue[17:16];
                    end
                end
                IMM_REQ: begin
                    readReq    <= 1'b1;
                    ramAddress <= {22'd0, ipPlusOneS, 2'b00};
                end
                IMM_WAIT: begin
                    if (readAck) begin
                        immR <= ramValue;
                    end
                end
                EXEC: begin
                    iPointer <= nextIpS;
                    if (aluWriteS) begin
                        regFile[srcAIdxR] <= aluResultS;
                    end
                end
                MEM_REQ: begin
                    if (opCode == OP_STORE) begin
                        writeReq   <= 1'b1;
                        ramAddress <= opAS;
                        ramOut     <= opBS;
                    end else begin
                        readReq    <= 1'b1;
                        ramAddress <= opBS;
                    end
                end
                MEM_WAIT: begin
                    if ((opCode == OP_LOAD) && readAck) begin
                        regFile[srcAIdxR] <= ramValue;
                    end
                end
                default: begin
                    readReq  <= 1'b0;
                    writeReq <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu.sv
// Directed bench for alu: runs small programs against a bus-level memory and an
// instruction-level reference model that predicts every bus request.
module tb_alu;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ramValue;
    logic        readAck;
    logic        writeAck;
    logic [31:0] ramAddress;
    logic [31:0] ramOut;
    logic        readReq;
    logic        writeReq;
    logic [7:0]  iPointer;
    logic [7:0]  opCode;
    logic [31:0] r0, r1, r2, debug;

    always #5 clk = ~clk;

    alu dut (
        .clk(clk), .reset(reset), .ramValue(ramValue), .readAck(readAck),
        .writeAck(writeAck), .ramAddress(ramAddress), .ramOut(ramOut),
        .readReq(readReq), .writeReq(writeReq), .iPointer(iPointer),
        .opCode(opCode), .r0(r0), .r1(r1), .r2(r2), .debug(debug)
    );

    typedef struct {
        bit          isWrite;
        bit          isFetch;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] s0, s1, s2, s3;
        logic [7:0]  ip;
        logic [7:0]  op;
        int          gap;
    } ev_t;

    ev_t         evq[$];
    ev_t         cev;
    logic [7:0]  mem [0:1023];
    logic [7:0]  mdl [0:1023];
    int          errs = 0;
    int          checks = 0;
    int          cyc = 0;
    int          lat = 0;
    int          lastFetch = 0;
    int          relCyc = 0;
    logic [31:0] fR [4];
    logic [7:0]  fIp, fOp;
    bit          prevRd = 1'b0;
    bit          mBusy = 1'b0;
    bit          mWrite = 1'b0;
    logic [31:0] mAddr = 32'd0;
    int          mCnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rdMem(input logic [31:0] a);
        logic [9:0] b;
        b = a[9:0];
        return {mem[b + 10'd3], mem[b + 10'd2], mem[b + 10'd1], mem[b]};
    endfunction

    function automatic logic [31:0] rdMdl(input logic [31:0] a);
        logic [9:0] b;
        b = a[9:0];
        return {mdl[b + 10'd3], mdl[b + 10'd2], mdl[b + 10'd1], mdl[b]};
    endfunction

    function automatic logic [31:0] enc(input logic [7:0] op, input logic [1:0] a, input logic [1:0] b);
        return {14'd0, b, 6'd0, a, op};
    endfunction

    task automatic clearMem();
        for (int i = 0; i < 1024; i++) begin
            mem[i] = 8'd0;
            mdl[i] = 8'd0;
        end
    endtask

    task automatic putw(input int idx, input logic [31:0] v);
        for (int k = 0; k < 4; k++) begin
            mem[idx * 4 + k] = v[8 * k +: 8];
            mdl[idx * 4 + k] = v[8 * k +: 8];
        end
    endtask

    // Instruction-set model: walks the program and queues every expected bus request.
    task automatic buildModel(input int e);
        logic [31:0] m [4];
        logic [31:0] w, imm;
        logic [7:0]  ip, prev, op;
        logic [1:0]  a, b;
        int          nPrev, nip, n;
        bit          halted, takesImm;
        ev_t         ev;
        for (int i = 0; i < 4; i++) m[i] = 32'd0;
        ip = 8'd0; prev = 8'd0; nPrev = 0; halted = 1'b0;
        evq.delete();
        for (int step = 0; step < 400 && !halted; step++) begin
            ev.isFetch = 1'b1; ev.isWrite = 1'b0; ev.data = 32'd0;
            ev.addr = 32'(int'(ip) * 4);
            ev.s0 = m[0]; ev.s1 = m[1]; ev.s2 = m[2]; ev.s3 = m[3];
            ev.ip = ip; ev.op = prev;
            ev.gap = (step == 0) ? 1 : 1 + nPrev * (3 + e);
            evq.push_back(ev);
            w = rdMdl(ev.addr);
            op = w[7:0]; a = w[9:8]; b = w[17:16];
            prev = op; n = 1; imm = 32'd0;
            takesImm = (op inside {8'h00, 8'h07, 8'h0A, 8'h0B, 8'h0C});
            ev.isFetch = 1'b0;
            if (takesImm) begin
                n = 2;
                ev.addr = 32'(((int'(ip) + 1) % 256) * 4);
                evq.push_back(ev);
                imm = rdMdl(ev.addr);
            end
            nip = (int'(ip) + (takesImm ? 2 : 1)) % 256;
            case (op)
                8'h00: m[a] = imm;
                8'h01: m[a] = m[b];
                8'h02: m[a] = m[a] + m[b];
                8'h03: m[a] = m[a] - m[b];
                8'h04: m[a] = m[a] & m[b];
                8'h05: m[a] = m[a] | m[b];
                8'h06: m[a] = m[a] ^ m[b];
                8'h07: m[a] = m[a] + imm;
                8'h0D: m[a] = m[a] << (m[b] % 32);
                8'h0E: m[a] = m[a] >> (m[b] % 32);
                8'h08: begin
                    n = 2;
                    ev.addr = m[b];
                    evq.push_back(ev);
                    m[a] = rdMdl(m[b]);
                end
                8'h09: begin
                    n = 2;
                    ev.isWrite = 1'b1; ev.addr = m[a]; ev.data = m[b];
                    evq.push_back(ev);
                    for (int k = 0; k < 4; k++) mdl[(m[a] + 32'(k)) % 1024] = m[b][8 * k +: 8];
                end
                8'h0A: nip = int'(imm[7:0]);
                8'h0B: if (m[a] == 32'd0) nip = int'(imm[7:0]);
                8'h0C: if (m[a] != 32'd0) nip = int'(imm[7:0]);
                default: halted = 1'b1;
            endcase
            ip = 8'(nip);
            nPrev = n;
        end
        for (int i = 0; i < 4; i++) fR[i] = m[i];
        fIp = ip; fOp = prev;
    endtask

    // Memory responder: acks each request (1 + lat) cycles after it is seen.
    initial begin
        forever begin
            @(negedge clk);
            readAck = 1'b0;
            writeAck = 1'b0;
            if (reset !== 1'b0) begin
                mBusy = 1'b0;
            end else if (mBusy) begin
                chk("addr held in wait", ramAddress, mAddr);
                mCnt--;
                if (mCnt == 0) begin
                    mBusy = 1'b0;
                    if (mWrite) begin
                        writeAck = 1'b1;
                    end else begin
                        readAck = 1'b1;
                        ramValue = rdMem(mAddr);
                    end
                end
            end else if (readReq === 1'b1 || writeReq === 1'b1) begin
                mBusy = 1'b1; mWrite = writeReq; mAddr = ramAddress; mCnt = 1 + lat;
                if (writeReq === 1'b1) begin
                    for (int k = 0; k < 4; k++) mem[(ramAddress + 32'(k)) % 1024] = ramOut[8 * k +: 8];
                end
            end
        end
    end

    // Compare process: every request against the model's predicted queue.
    initial begin
        forever begin
            @(negedge clk);
            if (reset !== 1'b0) begin
                prevRd = 1'b0;
            end else begin
                chk("req exclusive", 32'(readReq & writeReq), 32'd0);
                chk("read pulse width", 32'(readReq & prevRd), 32'd0);
                prevRd = readReq;
                if (readReq === 1'b1 || writeReq === 1'b1) begin
                    if (evq.size() == 0) begin
                        checks++; errs++;
                        $display("FAIL unexpected request: addr %h read %0d write %0d", ramAddress, readReq, writeReq);
                    end else begin
                        cev = evq.pop_front();
                        chk("req kind", 32'(writeReq), 32'(cev.isWrite));
                        chk("req addr", ramAddress, cev.addr);
                        if (cev.isWrite) chk("store data", ramOut, cev.data);
                        if (cev.isFetch) begin
                            chk("r0 at fetch", r0, cev.s0);
                            chk("r1 at fetch", r1, cev.s1);
                            chk("r2 at fetch", r2, cev.s2);
                            chk("debug at fetch", debug, cev.s3);
                            chk("iPointer at fetch", 32'(iPointer), 32'(cev.ip));
                            chk("opCode at fetch", 32'(opCode), 32'(cev.op));
                            chk("fetch spacing", 32'(cyc - lastFetch), 32'(cev.gap));
                            lastFetch = cyc;
                        end
                    end
                end
            end
        end
    end

    task automatic runProg(input int e);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        buildModel(e);
        lat = e;
        @(negedge clk);
        reset = 1'b0;
        lastFetch = cyc;
        relCyc = cyc;
        for (int t = 0; t < 4000 && evq.size() > 0; t++) @(negedge clk);
        if (evq.size() > 0) begin
            checks++; errs++;
            $display("FAIL program timeout: %0d requests outstanding", evq.size());
        end
        repeat (25) @(negedge clk);
        chk("final r0", r0, fR[0]);
        chk("final r1", r1, fR[1]);
        chk("final r2", r2, fR[2]);
        chk("final debug", debug, fR[3]);
        chk("final iPointer", 32'(iPointer), 32'(fIp));
        chk("final opCode", 32'(opCode), 32'(fOp));
    endtask

    initial begin
        reset = 1'b1; readAck = 1'b0; writeAck = 1'b0; ramValue = 32'd0;
        clearMem();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset ramAddress", ramAddress, 32'd0);
        chk("reset ramOut", ramOut, 32'd0);
        chk("reset readReq", 32'(readReq), 32'd0);
        chk("reset writeReq", 32'(writeReq), 32'd0);
        chk("reset iPointer", 32'(iPointer), 32'd0);
        chk("reset opCode", 32'(opCode), 32'd0);
        chk("reset r0", r0, 32'd0);
        chk("reset r1", r1, 32'd0);
        chk("reset r2", r2, 32'd0);
        chk("reset debug", debug, 32'd0);

        // arithmetic
        clearMem();
        putw(0, enc(8'h00, 2'd0, 2'd0)); putw(1, 32'h12345678);
        putw(2, enc(8'h00, 2'd1, 2'd0)); putw(3, 32'd5);
        putw(4, enc(8'h02, 2'd0, 2'd1));
        putw(5, 32'h0000000F);
        runProg(0);
        chk("P1 r0", r0, 32'h1234567D);
        chk("P1 r1", r1, 32'd5);
        chk("P1 iPointer", 32'(iPointer), 32'd6);
        chk("P1 opCode", 32'(opCode), 32'h0F);
        chk("P1 cycles to halt fetch", 32'(lastFetch - relCyc), 32'd19);

        // wrap and shift
        clearMem();
        putw(0, enc(8'h00, 2'd1, 2'd0)); putw(1, 32'd1);
        putw(2, enc(8'h03, 2'd0, 2'd1));
        putw(3, enc(8'h00, 2'd2, 2'd0)); putw(4, 32'd4);
        putw(5, enc(8'h0D, 2'd1, 2'd2));
        putw(6, 32'h0000000F);
        runProg(0);
        chk("P2 r0", r0, 32'hFFFFFFFF);
        chk("P2 r1", r1, 32'h00000010);
        chk("P2 iPointer", 32'(iPointer), 32'd7);

        // logic ops and shift right with a slower memory
        clearMem();
        putw(0, enc(8'h00, 2'd0, 2'd0)); putw(1, 32'hF0F0F0F0);
        putw(2, enc(8'h00, 2'd1, 2'd0)); putw(3, 32'h0FF00FF0);
        putw(4, enc(8'h01, 2'd2, 2'd0));
        putw(5, enc(8'h04, 2'd2, 2'd1));
        putw(6, enc(8'h01, 2'd3, 2'd0));
        putw(7, enc(8'h05, 2'd3, 2'd1));
        putw(8, enc(8'h06, 2'd0, 2'd1));
        putw(9, enc(8'h00, 2'd1, 2'd0)); putw(10, 32'd36);
        putw(11, enc(8'h0E, 2'd0, 2'd1));
        putw(12, 32'h0000000F);
        runProg(2);
        chk("P3 r0", r0, 32'h0FF00FF0);
        chk("P3 r2", r2, 32'h00F000F0);
        chk("P3 debug", debug, 32'hFFF0FFF0);
        chk("P3 iPointer", 32'(iPointer), 32'd13);

        // jumps ending on an illegal opcode
        clearMem();
        putw(0, enc(8'h0A, 2'd0, 2'd0)); putw(1, 32'd4);
        putw(2, 32'h0000000F);
        putw(4, enc(8'h0B, 2'd1, 2'd0)); putw(5, 32'd8);
        putw(6, 32'h0000000F);
        putw(8, enc(8'h00, 2'd1, 2'd0)); putw(9, 32'd7);
        putw(10, enc(8'h0B, 2'd1, 2'd0)); putw(11, 32'd0);
        putw(12, 32'h000000FF);
        runProg(0);
        chk("P6 opCode", 32'(opCode), 32'hFF);
        chk("P6 iPointer", 32'(iPointer), 32'd13);
        chk("P6 r1", r1, 32'd7);

        // store, load and an unaligned load
        clearMem();
        putw(0, enc(8'h00, 2'd2, 2'd0)); putw(1, 32'h00000100);
        putw(2, enc(8'h00, 2'd0, 2'd0)); putw(3, 32'hCAFEBABE);
        putw(4, enc(8'h09, 2'd2, 2'd0));
        putw(5, enc(8'h08, 2'd1, 2'd2));
        putw(6, enc(8'h07, 2'd2, 2'd0)); putw(7, 32'd1);
        putw(8, enc(8'h08, 2'd3, 2'd2));
        putw(9, 32'h0000000F);
        runProg(0);
        chk("P4 r1", r1, 32'hCAFEBABE);
        chk("P4 debug", debug, 32'h00CAFEBA);
        chk("P4 stored byte", 32'(mem[256]), 32'hBE);
        chk("P4 iPointer", 32'(iPointer), 32'd10);

        // countdown loop
        clearMem();
        putw(0, enc(8'h00, 2'd0, 2'd0)); putw(1, 32'd3);
        putw(2, enc(8'h07, 2'd0, 2'd0)); putw(3, 32'hFFFFFFFF);
        putw(4, enc(8'h0C, 2'd0, 2'd0)); putw(5, 32'd2);
        putw(6, 32'h0000000F);
        runProg(0);
        chk("P5 r0", r0, 32'd0);
        chk("P5 iPointer", 32'(iPointer), 32'd7);
        chk("P5 opCode", 32'(opCode), 32'h0F);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/alu.md
# alu

Multi-cycle 32-bit processor core for the Phaethon design. Fetches instructions from an external byte-addressed memory over a pulsed request/acknowledge interface and executes them on a four-entry register file. Exposes instruction pointer, current opcode, r0–r2 and a debug word for observation. Sits between the system clock/reset and the shared RAM model or controller.

## Interface
- No parameters.
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- ramValue  in  32  read data from memory; valid in the cycle readAck=1.
- readAck  in  1  one-cycle pulse: read data on ramValue is valid.
- writeAck  in  1  one-cycle pulse: write has completed.
- ramAddress  out  32  byte address of the current memory request.
- ramOut  out  32  write data for the current store.
- readReq  out  1  one-cycle read request pulse.
- writeReq  out  1  one-cycle write request pulse.
- iPointer  out  8  word index of the current instruction (byte address = iPointer*4).
- opCode  out  8  opcode of the most recently fetched instruction.
- r0, r1, r2  out  32  registers 0–2.
- debug  out  32  register r3.

## Operation
- Memory is little-endian, 32-bit word access at any byte address.
- Instruction word: [7:0] opcode, [9:8] register A, [17:16] register B; other bits ignored. "imm" is the following 32-bit word.
- Opcodes (A,B = register indices):
  - 00 MOVI A,imm: A=imm. 01 MOV A,B: A=B.
  - 02 ADD: A=A+B. 03 SUB: A=A-B. 04 AND. 05 OR. 06 XOR. All mod 2^32, no flags.
  - 07 ADDI A,imm: A=A+imm. 0D SHL: A=A<<B[4:0]. 0E SHR: logical, A=A>>B[4:0].
  - 08 LOAD A,[B]: A=mem32[B]. 09 STORE [A],B: mem32[A]=B.
  - 0A JMP imm: iPointer=imm[7:0]. 0B JZ A,imm / 0C JNZ A,imm: jump if A==0 / A!=0.
  - 0F HALT. Any other opcode is treated as HALT.
- iPointer advances by 1 for single-word and by 2 for imm instructions, including untaken branches. Arithmetic is mod 256.
- State machine: FETCH_REQ → FETCH_WAIT → (IMM_REQ → IMM_WAIT if imm) → EXEC → (MEM_REQ → MEM_WAIT for LOAD/STORE) → FETCH_REQ. HALT stays in HALTED until reset.
- *_REQ states drive ramAddress and pulse the request for exactly one cycle, then move to *_WAIT.
- *_WAIT states hold ramAddress/ramOut stable and wait indefinitely for the matching ack. Data is captured on the ack cycle.
- Acks received outside the matching WAIT state are ignored. readReq and writeReq are never high together.
- opCode is latched when the instruction word is captured.

## Timing
- Reset (sampled at clk edge): r0–r3, iPointer, opCode, ramAddress, ramOut = 0; readReq = writeReq = 0; state = FETCH_REQ.
- First readReq pulse (ramAddress = 0) occurs in the first cycle after reset deasserts.
- Reset mid-transaction abandons the request. The memory must be idle when reset is released.
- Register write occurs at the end of EXEC; for LOAD, at the end of the readAck cycle.
- Total latency per instruction: 2 + (memory latency per access) cycles.
  - With a memory answering ack two edges after the request (one-cycle request, one-cycle processing): 4 cycles for a single-word ALU op, 7 cycles for imm ops and loads/stores.
- Outputs r0–r2 and debug are direct register outputs with no extra delay.

## Test plan
- Reset: assert reset for 2 edges → all outputs 0. One readReq pulse with ramAddress=0 on the first cycle after release, then none until readAck.
- Arithmetic: MOVI r0,0x12345678; MOVI r1,5; ADD r0,r1; HALT → r0=0x1234567D, r1=5, iPointer=6, opCode=0F.
- Wrap and logic: MOVI r1,1; SUB r0,r1 (r0=0) → r0=0xFFFFFFFF. Then MOVI r2,4; SHL r1,r2 → r1=0x10.
- Memory: MOVI r2,0x100; MOVI r0,0xCAFEBABE; STORE [r2],r0 → one writeReq pulse, ramAddress=0x100, ramOut=0xCAFEBABE. Then LOAD r1,[r2] → r1=0xCAFEBABE.
- Loop: MOVI r0,3; ADDI r0,0xFFFFFFFF; JNZ r0,<addi index>; HALT → r0=0 after three passes, HALT reached, no further requests.
- Illegal/halt: fetch opcode 0xFF → opCode=FF, iPointer frozen, readReq/writeReq stay 0 for 20 cycles. Then reset → restart fetch at 0.
